// File: rtl/stream_demux1to2.sv
// Registered 1-to-2 stream demultiplexer: one valid/ready input steered by a per-word
// select bit into two independent 2-entry FIFOs. Define STREAM_DEMUX_CNT_EN for pop counters.

module stream_demux_q #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             full,
    output logic [15:0]      cnt
);
    logic [WIDTH-1:0] head, tail;
    logic [1:0]       occ;
    logic             pop;

    assign valid = (occ != 2'd0);
    assign full  = (occ == 2'd2);
    assign data  = head;
    assign pop   = valid & ready;

    // push is never asserted while full, so occ stays within 0..2
    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= push_data;
                    else             tail <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd2) head <= tail;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    // single entry leaving: new word lands straight in head
                    if (occ == 2'd1) head <= push_data;
                    else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef STREAM_DEMUX_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)      cnt <= '0;
        else if (pop) cnt <= cnt + 16'd1;
    end
`else
    assign cnt = '0;
`endif
endmodule

module stream_demux1to2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
);
    localparam int NUM_Q = 2;

    logic [NUM_Q-1:0][WIDTH-1:0] q_data;
    logic [NUM_Q-1:0][15:0]      q_cnt;
    logic [NUM_Q-1:0]            q_valid, q_ready, q_full, q_push;

    // ready looks only at the selected queue's fill level, never at consumer ready
    assign in_ready = ~q_full[in_sel];
    assign q_ready  = {out1_ready, out0_ready};

    for (genvar g = 0; g < NUM_Q; g++) begin : g_q
        assign q_push[g] = in_valid & in_ready & (in_sel == (g != 0));

        stream_demux_q #(.WIDTH(WIDTH)) u_q (
            .clk       (clk),
            .rst       (rst),
            .push      (q_push[g]),
            .push_data (in_data),
            .ready     (q_ready[g]),
            .valid     (q_valid[g]),
            .data      (q_data[g]),
            .full      (q_full[g]),
            .cnt       (q_cnt[g])
        );
    end

    assign out0_data  = q_data[0];
    assign out1_data  = q_data[1];
    assign out0_valid = q_valid[0];
    assign out1_valid = q_valid[1];
    assign cnt0       = q_cnt[0];
    assign cnt1       = q_cnt[1];
endmodule

// File: tb/tb_stream_demux1to2.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed
// literal checks for routing, backpressure, push/pop at full, mid-stream reset and counter wrap.

module tb_stream_demux1to2;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_sel, in_valid, in_ready;
    logic [WIDTH-1:0] out0_data, out1_data;
    logic             out0_valid, out0_ready, out1_valid, out1_ready;
    logic [15:0]      cnt0, cnt1;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    // reference model
    logic [WIDTH-1:0] mq0[$], mq1[$];
    logic [15:0]      m_cnt0 = '0, m_cnt1 = '0;

    stream_demux1to2 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model update: pops first, then the accepted word (push at full is impossible)
    always @(posedge clk) begin
        if (rst) begin
            mq0.delete();
            mq1.delete();
            m_cnt0 = '0;
            m_cnt1 = '0;
        end else begin
            logic acc;
            acc = in_valid && ((in_sel ? mq1.size() : mq0.size()) != 2);
            if (mq0.size() > 0 && out0_ready) begin void'(mq0.pop_front()); m_cnt0 = m_cnt0 + 16'd1; end
            if (mq1.size() > 0 && out1_ready) begin void'(mq1.pop_front()); m_cnt1 = m_cnt1 + 16'd1; end
            if (acc) begin
                if (in_sel) mq1.push_back(in_data);
                else        mq0.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready", in_ready, 32'((in_sel ? mq1.size() : mq0.size()) != 2));
            chk("m_out0_valid", out0_valid, 32'(mq0.size() != 0));
            chk("m_out1_valid", out1_valid, 32'(mq1.size() != 0));
            if (mq0.size() != 0) chk("m_out0_data", out0_data, mq0[0]);
            if (mq1.size() != 0) chk("m_out1_data", out1_data, mq1[0]);
`ifdef STREAM_DEMUX_CNT_EN
            chk("m_cnt0", cnt0, m_cnt0);
            chk("m_cnt1", cnt1, m_cnt1);
`else
            chk("m_cnt0", cnt0, 0);
            chk("m_cnt1", cnt1, 0);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out0_valid", out0_valid, 0);
        chk("rst_out1_valid", out1_valid, 0);
        chk("rst_out0_data", out0_data, 0);
        chk("rst_out1_data", out1_data, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        rst = 1'b0;

        // routing, 1-cycle latency
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h11); cyc();
        chk("route_11_valid", out0_valid, 1);
        chk("route_11_data", out0_data, 8'h11);
        drive(1'b1, 1'b1, 8'h22); cyc();
        chk("route_22_data", out1_data, 8'h22);
        chk("route_out0_empty", out0_valid, 0);
        drive(1'b1, 1'b0, 8'h33); cyc();
        chk("route_33_data", out0_data, 8'h33);
        chk("route_out1_empty", out1_valid, 0);
        drive(1'b0, 1'b0, '0); cyc();

        // backpressure on Q0, Q1 unaffected
        out0_ready = 1'b0;
        drive(1'b1, 1'b0, 8'hA1); cyc();
        drive(1'b1, 1'b0, 8'hA2); cyc();
        drive(1'b1, 1'b0, 8'hA3); #1;
        chk("bp_full_sel0", in_ready, 0);
        drive(1'b1, 1'b1, 8'hB1); #1;
        chk("bp_sel1_ready", in_ready, 1);
        cyc();
        drive(1'b0, 1'b0, '0);
        chk("bp_hold_a1", out0_data, 8'hA1);
        chk("bp_b1", out1_data, 8'hB1);
        cyc();
        chk("bp_hold_a1_2", out0_data, 8'hA1);
        out0_ready = 1'b1;
        cyc();
        chk("bp_rel_a2", out0_data, 8'hA2);
        cyc();
        chk("bp_drained", out0_valid, 0);

        // push to full Q1 while it pops
        out1_ready = 1'b0;
        drive(1'b1, 1'b1, 8'h01); cyc();
        drive(1'b1, 1'b1, 8'h02); cyc();
        out1_ready = 1'b1;
        drive(1'b1, 1'b1, 8'h03); #1;
        chk("pp_full_ready", in_ready, 0);
        cyc();
        chk("pp_head_02", out1_data, 8'h02);
        chk("pp_ready_again", in_ready, 1);
        cyc();
        drive(1'b0, 1'b0, '0);
        chk("pp_head_03", out1_data, 8'h03);
        cyc();
        chk("pp_drained", out1_valid, 0);

        // reset with Q0 full and Q1 holding one word
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1'b1, 1'b0, 8'hC1); cyc();
        drive(1'b1, 1'b0, 8'hC2); cyc();
        drive(1'b1, 1'b1, 8'hD1); cyc();
        drive(1'b0, 1'b0, '0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_v0", out0_valid, 0);
        chk("mid_rst_v1", out1_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_d0", out0_data, 0);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        repeat (3) cyc();
        chk("mid_rst_no_stale0", out0_valid, 0);
        chk("mid_rst_no_stale1", out1_valid, 0);

        // counter wrap: 65537 words through Q0
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 65537; i++) begin
            drive(1'b1, 1'b0, WIDTH'(i));
            cyc();
        end
        drive(1'b0, 1'b0, '0);
        repeat (3) cyc();
`ifdef STREAM_DEMUX_CNT_EN
        chk("wrap_cnt0", cnt0, 1);
`else
        chk("wrap_cnt0", cnt0, 0);
`endif
        chk("wrap_cnt1", cnt1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stream_demux1to2.md
# stream_demux1to2

Registered 1-to-2 stream demultiplexer: the inverse of the operand-select 2:1 mux. It takes one valid/ready stream of WIDTH-bit words from the Montgomery datapath and steers each word, by a per-word select bit, into one of two independent 2-entry output queues. It sits between the multiplier result register and its two consumers: the feedback path (next-round operand) and the final-result path. A stalled consumer never corrupts or reorders the other path.

## Interface
- WIDTH, 8, data word width in bits
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  word to route
- in_sel  input  1  destination: 0 → out0, 1 → out1
- in_valid  input  1  in_data/in_sel valid
- in_ready  output  1  word accepted on cycle when in_valid & in_ready
- out0_data  output  WIDTH  head word of queue 0
- out0_valid  output  1  queue 0 non-empty
- out0_ready  input  1  consumer 0 takes head when out0_valid & out0_ready
- out1_data / out1_valid / out1_ready  same as out0, for queue 1
- cnt0, cnt1  output  16  words delivered on out0 / out1 (see Configuration)

## Operation
- Two identical queues Q0, Q1, each 2 entries deep: head register, tail register, 2-bit occupancy (0, 1, 2).
- in_ready = (in_sel ? occ1 : occ0) != 2. This is combinational on in_sel and the occupancy registers only; it never depends on outN_ready. There is no pass-through when a queue is full.
- Push: on accept, the word is written to Qsel. If Qsel is empty, or holds 1 entry that is popping this same cycle, the word goes to head; otherwise it goes to tail.
- Pop: on outN_valid & outN_ready, tail moves to head (if occ=2) and occ decrements.
- Simultaneous push and pop on the same queue: occ is unchanged and FIFO order is preserved.
- Push to one queue and pop from the other on the same cycle are independent.
- Per-queue order is strict FIFO. There is no ordering relation between Q0 and Q1.
- outN_data = head register. It is held stable while outN_valid & !outN_ready.
- in_sel is only meaningful when in_valid=1. When in_valid=0, in_ready still reflects the current in_sel.
- Reset (any cycle, including mid-stream with queues full): occ0=occ1=0, head/tail=0, counters=0. Words held at reset are discarded.

## Timing
- Latency: a word accepted at edge t is visible on outN_valid/outN_data after edge t (cycle t+1). This holds when the queue was empty, or held 1 entry that popped at edge t.
- Throughput: 1 word/cycle per queue when its consumer holds ready=1.
- Reset values: in_ready=1 (both queues empty); out0_valid=out1_valid=0; out0_data=out1_data=0; cnt0=cnt1=0.
- All state updates occur on the rising clk edge. rst has priority over push and pop.

## Configuration
- STREAM_DEMUX_CNT_EN defined: cnt0/cnt1 are 16-bit registers. Each increments by 1 on every pop from its queue and wraps 0xFFFF→0x0000. rst clears them.
- STREAM_DEMUX_CNT_EN undefined: cnt0/cnt1 are tied to 0 and no counter flops are synthesised. The ports remain present.

## Test plan
- Reset then idle: after rst high for 2 cycles → in_ready=1, out0_valid=out1_valid=0, data=0, cnt=0.
- Routing: push 0x11 (sel0), 0x22 (sel1), 0x33 (sel0) on consecutive cycles with both readies=1 → out0 delivers 0x11, 0x33; out1 delivers 0x22; each word appears 1 cycle after acceptance.
- Backpressure/full: out0_ready=0, push 0xA1, 0xA2 to Q0 → third push with sel=0 sees in_ready=0. The same cycle with sel=1 gives in_ready=1 and is accepted. out0_data holds 0xA1 stable. Release → 0xA1, 0xA2 in order.
- Simultaneous push/pop at occ=2: Q1 holds 0x01, 0x02, out1_ready=1, push 0x03 (sel1) → in_ready=0 that cycle. Next cycle the push is accepted while 0x02 pops. Order on out1 is 0x01, 0x02, 0x03 with no loss or duplication.
- Reset mid-operation: Q0 full, Q1 holding 1 word, rst=1 for 1 cycle → both valids 0 next cycle, in_ready=1, and no stale word is ever emitted.
- Counter wrap (with STREAM_DEMUX_CNT_EN): 65537 pops on out0 → cnt0=1 and cnt1=0. Without the macro, cnt0 stays 0 throughout.
